supernova_prf_scb: RTL and testbench

SUPERNOVA_PRF_SCB -- requirements
Module: supernova_prf_scb

---
 rtl/supernova_pkg.sv | 12 +
 rtl/supernova_prf_scb_if.sv | 35 +++
 rtl/supernova_prf_ready_table.sv | 63 ++++++
 rtl/supernova_prf_scb.sv | 106 ++++++++++
 tb/tb_supernova_prf_scb.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/supernova_pkg.sv
// Shared core-wide sizing constants for the supernova register files.
package supernova_pkg;

   localparam int unsigned NUM_PHYS_GPRS  = 128;
   localparam int unsigned NUM_PHYS_FPRS  = 128;
   localparam int unsigned GPR_TAG_WIDTH  = $clog2(NUM_PHYS_GPRS);
   localparam int unsigned FPR_TAG_WIDTH  = $clog2(NUM_PHYS_FPRS);
   localparam int unsigned ISSUE_WIDTH    = 4;
   localparam int unsigned COMMIT_WIDTH   = 4;
   localparam int unsigned PRF_RD_LATENCY = 0;

endpackage

// File: rtl/supernova_prf_scb_if.sv
// Bundle of read, writeback, rename-allocation and scoreboard signals of one
// physical register file. The core side is master, the PRF is slave.
interface supernova_prf_scb_if
   import supernova_pkg::*;
#(
   parameter int unsigned NUM_REGS   = NUM_PHYS_GPRS,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NUM_RD     = 2 * ISSUE_WIDTH,
   parameter int unsigned NUM_WR     = ISSUE_WIDTH,
   parameter int unsigned NUM_ALLOC  = COMMIT_WIDTH
);
   localparam int unsigned TAGW = $clog2(NUM_REGS);

   logic [NUM_RD-1:0][TAGW-1:0]       rd_addr;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;
   logic [NUM_RD-1:0]                 rd_ready;
   logic [NUM_WR-1:0]                 wr_valid;
   logic [NUM_WR-1:0][TAGW-1:0]       wr_addr;
   logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data;
   logic [NUM_ALLOC-1:0]              alloc_valid;
   logic [NUM_ALLOC-1:0][TAGW-1:0]    alloc_tag;
   logic                              flush;
   logic [NUM_REGS-1:0]               ready_vec;

   modport master (
      output rd_addr, wr_valid, wr_addr, wr_data, alloc_valid, alloc_tag, flush,
      input  rd_data, rd_ready, ready_vec
   );

   modport slave (
      input  rd_addr, wr_valid, wr_addr, wr_data, alloc_valid, alloc_tag, flush,
      output rd_data, rd_ready, ready_vec
   );

endinterface

// File: rtl/supernova_prf_ready_table.sv
// Scoreboard of ready bits: alloc clears, writeback sets, flush sets all.
// Alloc beats write on the same tag; flush beats both.
module supernova_prf_ready_table
   import supernova_pkg::*;
#(
   parameter int unsigned NUM_REGS  = NUM_PHYS_GPRS,
   parameter int unsigned NUM_WR    = ISSUE_WIDTH,
   parameter int unsigned NUM_ALLOC = COMMIT_WIDTH,
   parameter int unsigned ZERO_REG  = 1,
   localparam int unsigned TAGW     = $clog2(NUM_REGS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_en,
   input  logic [NUM_WR-1:0]             i_wr_valid,
   input  logic [NUM_WR-1:0][TAGW-1:0]   i_wr_addr,
   input  logic [NUM_ALLOC-1:0]          i_alloc_valid,
   input  logic [NUM_ALLOC-1:0][TAGW-1:0] i_alloc_tag,
   input  logic                          i_flush,
   output logic [NUM_REGS-1:0]           o_ready_vec
);

   logic [NUM_REGS-1:0] r_ready;
   logic [NUM_REGS-1:0] w_ready_nxt;
   logic                w_alloc_dup;

   // Next ready state; later assignments carry higher priority.
   always_comb begin
      w_ready_nxt = r_ready;
      if (i_en) begin
         for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (i_wr_valid[w]) w_ready_nxt[i_wr_addr[w]] = 1'b1;
         end
         for (int unsigned a = 0; a < NUM_ALLOC; a++) begin
            if (i_alloc_valid[a]) w_ready_nxt[i_alloc_tag[a]] = 1'b0;
         end
      end
      if (ZERO_REG != 0) w_ready_nxt[0] = 1'b1;
      if (i_flush) w_ready_nxt = '1;
   end

   // Ready bit register, all-ready out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_ready <= '1;
      else     r_ready <= w_ready_nxt;
   end

   // Detect two alloc ports naming the same valid tag.
   always_comb begin
      w_alloc_dup = 1'b0;
      for (int unsigned a = 0; a < NUM_ALLOC; a++) begin
         for (int unsigned b = a + 1; b < NUM_ALLOC; b++) begin
            if (i_alloc_valid[a] && i_alloc_valid[b] && (i_alloc_tag[a] == i_alloc_tag[b]))
               w_alloc_dup = 1'b1;
         end
      end
   end

   a_alloc_unique: assert property (@(posedge clk) disable iff (rst) !w_alloc_dup);

   assign o_ready_vec = r_ready;

endmodule

// File: rtl/supernova_prf_scb.sv
// Physical register file with integrated ready scoreboard and write-first
// read bypass. ZERO_REG=1 hardwires tag 0 to zero/ready (GPR mode).
module supernova_prf_scb
   import supernova_pkg::*;
#(
   parameter int unsigned NUM_REGS   = NUM_PHYS_GPRS,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NUM_RD     = 2 * ISSUE_WIDTH,
   parameter int unsigned NUM_WR     = ISSUE_WIDTH,
   parameter int unsigned NUM_ALLOC  = COMMIT_WIDTH,
   parameter int unsigned ZERO_REG   = 1,
   parameter int unsigned RD_LATENCY = PRF_RD_LATENCY,
   localparam int unsigned TAGW      = $clog2(NUM_REGS)
) (
   input logic                 clk,
   input logic                 rst,
   supernova_prf_scb_if.slave  s_bus
);

   logic [DATA_WIDTH-1:0]             r_mem [NUM_REGS];
   logic                              r_run;
   logic [NUM_REGS-1:0]               w_ready_vec;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0] w_rd_data;
   logic [NUM_RD-1:0]                 w_rd_ready;

   // The first edge after reset release still counts as reset, so writes and
   // allocs are gated by this register rather than by rst itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_run <= 1'b0;
      else     r_run <= 1'b1;
   end

   // Data array write; ascending port order lets the highest port win.
   always_ff @(posedge clk) begin
      if (r_run) begin
         for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (s_bus.wr_valid[w] && !((ZERO_REG != 0) && (s_bus.wr_addr[w] == '0)))
               r_mem[s_bus.wr_addr[w]] <= s_bus.wr_data[w];
         end
      end
   end

   supernova_prf_ready_table #(
      .NUM_REGS  (NUM_REGS),
      .NUM_WR    (NUM_WR),
      .NUM_ALLOC (NUM_ALLOC),
      .ZERO_REG  (ZERO_REG)
   ) u_ready_table (
      .clk           (clk),
      .rst           (rst),
      .i_en          (r_run),
      .i_wr_valid    (s_bus.wr_valid),
      .i_wr_addr     (s_bus.wr_addr),
      .i_alloc_valid (s_bus.alloc_valid),
      .i_alloc_tag   (s_bus.alloc_tag),
      .i_flush       (s_bus.flush),
      .o_ready_vec   (w_ready_vec)
   );

   // Read with write-first bypass; alloc is deliberately not looked at.
   always_comb begin
      w_rd_data  = '0;
      w_rd_ready = '0;
      for (int unsigned r = 0; r < NUM_RD; r++) begin
         w_rd_data[r]  = r_mem[s_bus.rd_addr[r]];
         w_rd_ready[r] = w_ready_vec[s_bus.rd_addr[r]];
         if (r_run) begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
               if (s_bus.wr_valid[w] && (s_bus.wr_addr[w] == s_bus.rd_addr[r])) begin
                  w_rd_data[r]  = s_bus.wr_data[w];
                  w_rd_ready[r] = 1'b1;
               end
            end
         end
         if ((ZERO_REG != 0) && (s_bus.rd_addr[r] == '0)) begin
            w_rd_data[r]  = '0;
            w_rd_ready[r] = 1'b1;
         end
      end
   end

   if (RD_LATENCY == 0) begin : g_rd_comb
      assign s_bus.rd_data  = w_rd_data;
      assign s_bus.rd_ready = w_rd_ready;
   end else begin : g_rd_reg
      logic [NUM_RD-1:0][DATA_WIDTH-1:0] r_rd_data;
      logic [NUM_RD-1:0]                 r_rd_ready;

      // Registered read captures the bypassed value, i.e. post-edge contents.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_rd_data  <= '0;
            r_rd_ready <= '1;
         end else begin
            r_rd_data  <= w_rd_data;
            r_rd_ready <= w_rd_ready;
         end
      end

      assign s_bus.rd_data  = r_rd_data;
      assign s_bus.rd_ready = r_rd_ready;
   end

   assign s_bus.ready_vec = w_ready_vec;

endmodule

// File: tb/tb_supernova_prf_scb.sv
// Bench for supernova_prf_scb: a GPR instance (ZERO_REG=1) and an FPR
// instance (ZERO_REG=0) share one stimulus stream and one reference model.
module tb_supernova_prf_scb;

   localparam int NR  = 32;
   localparam int DW  = 64;
   localparam int NRD = 8;
   localparam int NWR = 4;
   localparam int NAL = 4;
   localparam int TW  = $clog2(NR);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NRD-1:0][TW-1:0] b_rd_addr;
   logic [NWR-1:0]         b_wr_valid;
   logic [NWR-1:0][TW-1:0] b_wr_addr;
   logic [NWR-1:0][DW-1:0] b_wr_data;
   logic [NAL-1:0]         b_alloc_valid;
   logic [NAL-1:0][TW-1:0] b_alloc_tag;
   logic                   b_flush;

   supernova_prf_scb_if #(.NUM_REGS(NR), .DATA_WIDTH(DW), .NUM_RD(NRD), .NUM_WR(NWR), .NUM_ALLOC(NAL)) ig ();
   supernova_prf_scb_if #(.NUM_REGS(NR), .DATA_WIDTH(DW), .NUM_RD(NRD), .NUM_WR(NWR), .NUM_ALLOC(NAL)) ifp ();

   assign ig.rd_addr      = b_rd_addr;
   assign ig.wr_valid     = b_wr_valid;
   assign ig.wr_addr      = b_wr_addr;
   assign ig.wr_data      = b_wr_data;
   assign ig.alloc_valid  = b_alloc_valid;
   assign ig.alloc_tag    = b_alloc_tag;
   assign ig.flush        = b_flush;
   assign ifp.rd_addr     = b_rd_addr;
   assign ifp.wr_valid    = b_wr_valid;
   assign ifp.wr_addr     = b_wr_addr;
   assign ifp.wr_data     = b_wr_data;
   assign ifp.alloc_valid = b_alloc_valid;
   assign ifp.alloc_tag   = b_alloc_tag;
   assign ifp.flush       = b_flush;

   supernova_prf_scb #(.NUM_REGS(NR), .DATA_WIDTH(DW), .NUM_RD(NRD), .NUM_WR(NWR),
                       .NUM_ALLOC(NAL), .ZERO_REG(1), .RD_LATENCY(0))
      u_gpr (.clk(clk), .rst(rst), .s_bus(ig));

   supernova_prf_scb #(.NUM_REGS(NR), .DATA_WIDTH(DW), .NUM_RD(NRD), .NUM_WR(NWR),
                       .NUM_ALLOC(NAL), .ZERO_REG(0), .RD_LATENCY(0))
      u_fpr (.clk(clk), .rst(rst), .s_bus(ifp));

   // Reference model: index 0 = GPR instance, 1 = FPR instance.
   logic [DW-1:0] m_mem   [2][NR];
   bit            m_known [2][NR];
   bit            m_rdy   [2][NR];
   bit            m_run;

   int vectors = 0;
   int miscompares = 0;

   function automatic bit is_zero(int d, int t);
      return (d == 0) && (t == 0);
   endfunction

   // Highest-numbered write port targeting t this cycle, or -1.
   function automatic int last_writer(int t);
      int p = -1;
      if (!m_run) return -1;
      for (int w = 0; w < NWR; w++)
         if (b_wr_valid[w] && int'(b_wr_addr[w]) == t) p = w;
      return p;
   endfunction

   function automatic logic [DW-1:0] exp_data(int d, int t);
      int p = last_writer(t);
      if (is_zero(d, t)) return '0;
      if (p >= 0) return b_wr_data[p];
      return m_mem[d][t];
   endfunction

   function automatic bit exp_rdy(int d, int t);
      if (is_zero(d, t)) return 1'b1;
      if (last_writer(t) >= 0) return 1'b1;
      return m_rdy[d][t];
   endfunction

   function automatic bit exp_known(int d, int t);
      return is_zero(d, t) || (last_writer(t) >= 0) || m_known[d][t];
   endfunction

   function automatic logic [NR-1:0] exp_vec(int d);
      logic [NR-1:0] v;
      for (int t = 0; t < NR; t++) v[t] = m_rdy[d][t];
      return v;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int t = 0; t < NR; t++) m_rdy[d][t] = 1'b1;
      m_run = 1'b0;
   endtask

   // Advance the model across one clock edge using the inputs now applied.
   task automatic step_model();
      bit wr, al;
      int p;
      if (rst) begin
         model_reset();
         return;
      end
      if (!m_run) begin
         m_run = 1'b1;
         return;
      end
      for (int d = 0; d < 2; d++) begin
         for (int t = 0; t < NR; t++) begin
            if (is_zero(d, t)) continue;
            p  = last_writer(t);
            wr = (p >= 0);
            al = 1'b0;
            for (int a = 0; a < NAL; a++)
               if (b_alloc_valid[a] && int'(b_alloc_tag[a]) == t) al = 1'b1;
            if (wr) begin
               m_mem[d][t]   = b_wr_data[p];
               m_known[d][t] = 1'b1;
            end
            if (b_flush)  m_rdy[d][t] = 1'b1;
            else if (al)  m_rdy[d][t] = 1'b0;
            else if (wr)  m_rdy[d][t] = 1'b1;
         end
      end
   endtask

   task automatic tick();
      step_model();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      b_rd_addr     = '0;
      b_wr_valid    = '0;
      b_wr_addr     = '0;
      b_wr_data     = '0;
      b_alloc_valid = '0;
      b_alloc_tag   = '0;
      b_flush       = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      tick();
      tick();
      // Release with an alloc in the same cycle: it must be ignored.
      rst = 1'b0;
      b_alloc_valid[0] = 1'b1;
      b_alloc_tag[0]   = TW'(7);
      tick();
      vectors++;
      if (ig.ready_vec !== '1) begin
         miscompares++;
         $display("FAIL release_alloc gpr ready_vec got=%h exp=all-ones", ig.ready_vec);
      end
      vectors++;
      if (ifp.ready_vec !== '1) begin
         miscompares++;
         $display("FAIL release_alloc fpr ready_vec got=%h exp=all-ones", ifp.ready_vec);
      end
      // Now the alloc must take effect.
      tick();
      vectors++;
      if (ig.ready_vec[7] !== 1'b0) begin
         miscompares++;
         $display("FAIL alloc_after_release gpr ready[7] got=%b exp=0", ig.ready_vec[7]);
      end
      // Asynchronous assert: all-ready without waiting for an edge.
      rst = 1'b1;
      model_reset();
      #1;
      vectors++;
      if (ig.ready_vec !== '1 || ifp.ready_vec !== '1) begin
         miscompares++;
         $display("FAIL async_reset ready_vec got=%h/%h exp=all-ones", ig.ready_vec, ifp.ready_vec);
      end
      // Writes and allocs during reset have no effect on readiness.
      b_wr_valid[1] = 1'b1;
      b_wr_addr[1]  = TW'(5);
      b_wr_data[1]  = 64'h1111;
      b_alloc_tag[0] = TW'(5);
      @(negedge clk);
      tick();
      clear_inputs();
      rst = 1'b0;
      b_rd_addr[0] = TW'(5);
      #1;
      vectors++;
      if (ig.rd_ready[0] !== 1'b1 || ifp.rd_ready[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_rd_ready tag5 got=%b/%b exp=1", ig.rd_ready[0], ifp.rd_ready[0]);
      end
      tick();
      vectors++;
      if (ig.ready_vec !== exp_vec(0) || ifp.ready_vec !== exp_vec(1)) begin
         miscompares++;
         $display("FAIL reset_ready_vec got=%h/%h exp=%h/%h", ig.ready_vec, ifp.ready_vec, exp_vec(0), exp_vec(1));
      end
   endtask

   task automatic test_alloc_write();
      clear_inputs();
      b_alloc_valid[0] = 1'b1;
      b_alloc_tag[0]   = TW'(9);
      tick();
      clear_inputs();
      vectors++;
      if (ig.ready_vec[9] !== 1'b0 || ifp.ready_vec[9] !== 1'b0) begin
         miscompares++;
         $display("FAIL alloc9 ready got=%b/%b exp=0", ig.ready_vec[9], ifp.ready_vec[9]);
      end
      tick();
      tick();
      vectors++;
      if (ig.ready_vec[9] !== 1'b0) begin
         miscompares++;
         $display("FAIL alloc9_hold ready got=%b exp=0", ig.ready_vec[9]);
      end
      b_wr_valid[0] = 1'b1;
      b_wr_addr[0]  = TW'(9);
      b_wr_data[0]  = 64'hDEAD;
      tick();
      clear_inputs();
      b_rd_addr[0] = TW'(9);
      #1;
      vectors++;
      if (ig.ready_vec[9] !== 1'b1 || ifp.ready_vec[9] !== 1'b1) begin
         miscompares++;
         $display("FAIL write9 ready got=%b/%b exp=1", ig.ready_vec[9], ifp.ready_vec[9]);
      end
      vectors++;
      if (ig.rd_data[0] !== 64'hDEAD || ifp.rd_data[0] !== 64'hDEAD || ig.rd_ready[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL read9 data got=%h/%h exp=dead", ig.rd_data[0], ifp.rd_data[0]);
      end
   endtask

   task automatic test_bypass();
      clear_inputs();
      b_alloc_valid[2] = 1'b1;
      b_alloc_tag[2]   = TW'(12);
      tick();
      clear_inputs();
      b_rd_addr[1]  = TW'(12);
      b_wr_valid[2] = 1'b1;
      b_wr_addr[2]  = TW'(12);
      b_wr_data[2]  = 64'h1234;
      b_wr_valid[3] = 1'b1;
      b_wr_addr[3]  = TW'(12);
      b_wr_data[3]  = 64'h5678;
      #1;
      vectors++;
      if (ig.rd_data[1] !== 64'h5678 || ifp.rd_data[1] !== 64'h5678) begin
         miscompares++;
         $display("FAIL bypass12 data got=%h/%h exp=5678", ig.rd_data[1], ifp.rd_data[1]);
      end
      vectors++;
      if (ig.rd_ready[1] !== 1'b1 || ifp.rd_ready[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL bypass12 ready got=%b/%b exp=1", ig.rd_ready[1], ifp.rd_ready[1]);
      end
      tick();
      clear_inputs();
      b_rd_addr[1] = TW'(12);
      #1;
      vectors++;
      if (ig.rd_data[1] !== 64'h5678 || ifp.rd_data[1] !== 64'h5678) begin
         miscompares++;
         $display("FAIL array12 data got=%h/%h exp=5678", ig.rd_data[1], ifp.rd_data[1]);
      end
   endtask

   task automatic test_conflict();
      clear_inputs();
      b_alloc_valid[1] = 1'b1;
      b_alloc_tag[1]   = TW'(20);
      b_wr_valid[1]    = 1'b1;
      b_wr_addr[1]     = TW'(20);
      b_wr_data[1]     = 64'hCAFE_F00D;
      tick();
      clear_inputs();
      b_rd_addr[2] = TW'(20);
      #1;
      vectors++;
      if (ig.ready_vec[20] !== 1'b0 || ifp.ready_vec[20] !== 1'b0) begin
         miscompares++;
         $display("FAIL conflict20 ready got=%b/%b exp=0", ig.ready_vec[20], ifp.ready_vec[20]);
      end
      vectors++;
      if (ig.rd_data[2] !== 64'hCAFE_F00D || ifp.rd_data[2] !== 64'hCAFE_F00D || ig.rd_ready[2] !== 1'b0) begin
         miscompares++;
         $display("FAIL conflict20 data got=%h rdy=%b exp=cafef00d rdy=0", ig.rd_data[2], ig.rd_ready[2]);
      end
   endtask

   task automatic test_flush();
      clear_inputs();
      for (int a = 0; a < 3; a++) begin
         b_alloc_valid[a] = 1'b1;
         b_alloc_tag[a]   = TW'(3 + a);
      end
      tick();
      clear_inputs();
      vectors++;
      if (ig.ready_vec[5:3] !== 3'b000 || ifp.ready_vec[5:3] !== 3'b000) begin
         miscompares++;
         $display("FAIL alloc345 ready got=%b/%b exp=000", ig.ready_vec[5:3], ifp.ready_vec[5:3]);
      end
      b_flush          = 1'b1;
      b_alloc_valid[0] = 1'b1;
      b_alloc_tag[0]   = TW'(6);
      tick();
      clear_inputs();
      vectors++;
      if (ig.ready_vec !== '1 || ifp.ready_vec !== '1) begin
         miscompares++;
         $display("FAIL flush ready_vec got=%h/%h exp=all-ones", ig.ready_vec, ifp.ready_vec);
      end
   endtask

   task automatic test_zero_reg();
      clear_inputs();
      b_wr_valid[0]    = 1'b1;
      b_wr_addr[0]     = '0;
      b_wr_data[0]     = 64'hFF;
      b_alloc_valid[0] = 1'b1;
      b_alloc_tag[0]   = '0;
      b_rd_addr[3]     = '0;
      #1;
      vectors++;
      if (ig.rd_data[3] !== '0 || ig.rd_ready[3] !== 1'b1) begin
         miscompares++;
         $display("FAIL zero_gpr_bypass got=%h rdy=%b exp=0 rdy=1", ig.rd_data[3], ig.rd_ready[3]);
      end
      vectors++;
      if (ifp.rd_data[3] !== 64'hFF || ifp.rd_ready[3] !== 1'b1) begin
         miscompares++;
         $display("FAIL zero_fpr_bypass got=%h rdy=%b exp=ff rdy=1", ifp.rd_data[3], ifp.rd_ready[3]);
      end
      tick();
      clear_inputs();
      b_rd_addr[3] = '0;
      #1;
      vectors++;
      if (ig.rd_data[3] !== '0 || ig.rd_ready[3] !== 1'b1 || ig.ready_vec[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL zero_gpr got=%h rdy=%b vec0=%b exp=0 1 1", ig.rd_data[3], ig.rd_ready[3], ig.ready_vec[0]);
      end
      vectors++;
      if (ifp.rd_data[3] !== 64'hFF || ifp.rd_ready[3] !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_fpr got=%h rdy=%b exp=ff rdy=0", ifp.rd_data[3], ifp.rd_ready[3]);
      end
   endtask

   task automatic test_random();
      int span;
      bit dup;
      clear_inputs();
      // Give every tag a known value first.
      for (int base = 0; base < NR; base += NWR) begin
         for (int w = 0; w < NWR; w++) begin
            b_wr_valid[w] = 1'b1;
            b_wr_addr[w]  = TW'(base + w);
            b_wr_data[w]  = {$urandom, $urandom};
         end
         tick();
      end
      clear_inputs();
      for (int cyc = 0; cyc < 400; cyc++) begin
         span = (cyc % 2 == 0) ? 7 : NR - 1;
         for (int w = 0; w < NWR; w++) begin
            b_wr_valid[w] = 1'($urandom_range(0, 1));
            b_wr_addr[w]  = TW'($urandom_range(0, span));
            b_wr_data[w]  = {$urandom, $urandom};
         end
         for (int a = 0; a < NAL; a++) begin
            b_alloc_tag[a]   = TW'($urandom_range(0, span));
            b_alloc_valid[a] = ($urandom_range(0, 2) == 0);
            dup = 1'b0;
            for (int k = 0; k < a; k++)
               if (b_alloc_valid[k] && b_alloc_tag[k] == b_alloc_tag[a]) dup = 1'b1;
            if (dup) b_alloc_valid[a] = 1'b0;
         end
         b_flush = ($urandom_range(0, 15) == 0);
         for (int r = 0; r < NRD; r++) b_rd_addr[r] = TW'($urandom_range(0, span));
         #1;
         for (int r = 0; r < NRD; r++) begin
            vectors++;
            if (ig.rd_ready[r] !== exp_rdy(0, int'(b_rd_addr[r])) ||
                ifp.rd_ready[r] !== exp_rdy(1, int'(b_rd_addr[r]))) begin
               miscompares++;
               $display("FAIL rand_rdy cyc=%0d port=%0d tag=%0d got=%b/%b exp=%b/%b", cyc, r, b_rd_addr[r],
                        ig.rd_ready[r], ifp.rd_ready[r], exp_rdy(0, int'(b_rd_addr[r])), exp_rdy(1, int'(b_rd_addr[r])));
            end
            if (exp_known(0, int'(b_rd_addr[r])) && exp_known(1, int'(b_rd_addr[r]))) begin
               vectors++;
               if (ig.rd_data[r] !== exp_data(0, int'(b_rd_addr[r])) ||
                   ifp.rd_data[r] !== exp_data(1, int'(b_rd_addr[r]))) begin
                  miscompares++;
                  $display("FAIL rand_data cyc=%0d port=%0d tag=%0d got=%h/%h exp=%h/%h", cyc, r, b_rd_addr[r],
                           ig.rd_data[r], ifp.rd_data[r], exp_data(0, int'(b_rd_addr[r])), exp_data(1, int'(b_rd_addr[r])));
               end
            end
         end
         tick();
         vectors++;
         if (ig.ready_vec !== exp_vec(0) || ifp.ready_vec !== exp_vec(1)) begin
            miscompares++;
            $display("FAIL rand_ready_vec cyc=%0d got=%h/%h exp=%h/%h", cyc, ig.ready_vec, ifp.ready_vec, exp_vec(0), exp_vec(1));
         end
      end
      clear_inputs();
   endtask

   initial begin
      for (int d = 0; d < 2; d++)
         for (int t = 0; t < NR; t++) begin
            m_mem[d][t]   = '0;
            m_known[d][t] = 1'b0;
         end
      model_reset();
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_alloc_write();
      test_bypass();
      test_conflict();
      test_flush();
      test_zero_reg();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
